// File: rtl/nmi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nmi_arbiter
//  Purpose  : Shares the Z80 /NMI line between four requesters (magic, pause,
//             divMMC, external). Requests are synchronised, debounced and
//             latched as pending; one is granted per frame interrupt edge,
//             /NMI is held until the 0x0066 vector fetch, and the block then
//             waits for the handler to report completion.
//  Ports    : clk28, rst_n           - 28 MHz clock, async active-low reset
//             bus_*                  - CPU bus monitor (observed only)
//             req[3:0], mask[3:0]    - raw requests / requester disables
//             n_int, n_int_next      - current / next-cycle frame interrupt
//             map_active             - magic ROM mapped (gates status port)
//             nmi_done               - handler finished pulse
//             n_nmi, grant, nmi_active, d_out, d_out_active - outputs
//  Revision : 1.0 - initial release
// ============================================================================
module nmi_arbiter #(
  parameter int DEBOUNCE_W = 16,
  parameter int TIMEOUT_W  = 20
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        bus_mreq,
  input  logic        bus_ioreq,
  input  logic        bus_m1,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [15:0] bus_a,
  input  logic [7:0]  bus_d,
  input  logic [3:0]  req,
  input  logic [3:0]  mask,
  input  logic        n_int,
  input  logic        n_int_next,
  input  logic        map_active,
  input  logic        nmi_done,
  output logic        n_nmi,
  output logic [1:0]  grant,
  output logic        nmi_active,
  output logic [7:0]  d_out,
  output logic        d_out_active
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_EDGE = 2'd1,
    S_ASSERT    = 2'd2,
    S_SERVICE   = 2'd3
  } state_t;

  localparam logic [DEBOUNCE_W-1:0] c_deb_max = '1;
  localparam logic [TIMEOUT_W-1:0]  c_tmo_max = '1;

  state_t                 r_state;
  logic [3:0]             w_deb;
  logic [3:0]             r_deb_q;
  logic [3:0]             r_pend;
  logic [TIMEOUT_W-1:0]   r_tmo_cnt;
  logic                   r_tmo_flag;

  logic [3:0]             w_rise;
  logic [3:0]             w_elig;
  logic [3:0]             w_gclr;
  logic [1:0]             w_pick;
  logic                   w_frame;
  logic                   w_fetch;
  logic                   w_sel;
  logic                   w_grant_now;
  logic                   w_timeout;
  logic                   w_unused_bus;

  // The data bus and write strobe are visible on the monitor but play no part
  // here: port writes are deliberately ignored.
  assign w_unused_bus = ^{bus_wr, bus_d};

  // --------------------------------------------------------------------------
  // Per-requester synchroniser and debouncer. The counter runs only while the
  // synchronised level differs from the accepted level, so any bounce back to
  // the accepted level restarts the stability window.
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_req
    logic [1:0]            r_sync;
    logic [DEBOUNCE_W-1:0] r_cnt;
    logic                  r_deb;

    always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= 2'b00;
        r_cnt  <= '0;
        r_deb  <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], req[i]};
        if (r_sync[1] == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_max) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_deb[i] = r_deb;
  end

  assign w_rise      = w_deb & ~r_deb_q;
  assign w_elig      = r_pend & ~mask;
  assign w_frame     = n_int & ~n_int_next;
  assign w_fetch     = bus_m1 & bus_mreq & (bus_a == 16'h0066);
  assign w_sel       = map_active & bus_ioreq & bus_rd & (bus_a == 16'hFEFF);
  assign w_grant_now = (r_state == S_WAIT_EDGE) & w_frame & (|w_elig);
  // Fetch wins over a timeout landing in the same cycle.
  assign w_timeout   = (r_state == S_ASSERT) & ~w_fetch & (r_tmo_cnt == c_tmo_max);

  // Fixed priority: lowest index wins.
  always_comb begin
    w_pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[i]) w_pick = 2'(i);
    end
  end

  assign w_gclr = w_grant_now ? (4'b0001 << w_pick) : 4'b0000;

  // A new rising edge beats a grant clear in the same cycle so a re-request
  // from the source being granted is never lost; repeats simply collapse.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_q <= 4'b0000;
      r_pend  <= 4'b0000;
    end else begin
      r_deb_q <= w_deb;
      r_pend  <= ~mask & ((r_pend & ~w_gclr) | w_rise);
    end
  end

  // --------------------------------------------------------------------------
  // Grant / service sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      n_nmi      <= 1'b1;
      grant      <= 2'd0;
      nmi_active <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|r_pend) r_state <= S_WAIT_EDGE;
        end
        S_WAIT_EDGE: begin
          if (w_grant_now) begin
            grant      <= w_pick;
            n_nmi      <= 1'b0;
            nmi_active <= 1'b1;
            r_tmo_cnt  <= '0;
            r_state    <= S_ASSERT;
          end else if (~|r_pend) begin
            r_state <= S_IDLE;
          end
        end
        S_ASSERT: begin
          if (w_fetch) begin
            n_nmi   <= 1'b1;
            r_state <= S_SERVICE;
          end else if (w_timeout) begin
            n_nmi      <= 1'b1;
            nmi_active <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_SERVICE: begin
          if (nmi_done) begin
            nmi_active <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status port. The snapshot is taken from registered state, so the first
  // read after a timeout still shows the flag even though it clears then.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      d_out        <= 8'h00;
      d_out_active <= 1'b0;
      r_tmo_flag   <= 1'b0;
    end else begin
      d_out        <= w_sel ? {nmi_active, r_tmo_flag, grant, r_pend} : 8'h00;
      d_out_active <= w_sel;
      if (w_timeout) begin
        r_tmo_flag <= 1'b1;
      end else if (w_sel & ~d_out_active) begin
        r_tmo_flag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nmi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nmi_arbiter
//  Purpose  : Self-checking bench for nmi_arbiter: directed scenarios with
//             literal expectations, then randomized traffic, all outputs
//             compared every cycle against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nmi_arbiter;

  localparam int DW  = 4;
  localparam int TW  = 7;
  localparam int HL  = (1 << DW) + 2;
  localparam int TMO = 1 << TW;
  localparam int FP  = 60;

  logic        clk28 = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_mreq = 1'b0, bus_ioreq = 1'b0, bus_m1 = 1'b0;
  logic        bus_rd = 1'b0, bus_wr = 1'b0;
  logic [15:0] bus_a = 16'h0000;
  logic [7:0]  bus_d = 8'h00;
  logic [3:0]  req = 4'h0, mask = 4'h0;
  logic        n_int = 1'b1, n_int_next = 1'b1;
  logic        map_active = 1'b1, nmi_done = 1'b0;
  logic        n_nmi, nmi_active, d_out_active;
  logic [1:0]  grant;
  logic [7:0]  d_out;

  int n_vec = 0;
  int n_bad = 0;

  nmi_arbiter #(.DEBOUNCE_W(DW), .TIMEOUT_W(TW)) dut (
    .clk28(clk28), .rst_n(rst_n),
    .bus_mreq(bus_mreq), .bus_ioreq(bus_ioreq), .bus_m1(bus_m1),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_a(bus_a), .bus_d(bus_d),
    .req(req), .mask(mask), .n_int(n_int), .n_int_next(n_int_next),
    .map_active(map_active), .nmi_done(nmi_done),
    .n_nmi(n_nmi), .grant(grant), .nmi_active(nmi_active),
    .d_out(d_out), .d_out_active(d_out_active)
  );

  always #5 clk28 = ~clk28;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: raw request history window, pending set, and a plain
  // description of where the arbiter is (waiting / pulling /NMI / in handler).
  // --------------------------------------------------------------------------
  logic [HL-1:0] m_hist [4];
  logic [3:0]    m_deb = 0, m_deb_d = 0, m_pend = 0;
  bit            m_armed = 0, m_low = 0, m_act = 0, m_tflag = 0, m_dact = 0;
  int            m_low_cycles = 0;
  logic [1:0]    m_grant = 0;
  logic [7:0]    m_dout = 0;

  always @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
      m_deb = 0; m_deb_d = 0; m_pend = 0;
      m_armed = 0; m_low = 0; m_act = 0; m_tflag = 0; m_dact = 0;
      m_low_cycles = 0; m_grant = 0; m_dout = 0;
    end else begin
      logic [3:0]    rise, elig, gclr, ndeb;
      logic [HL-3:0] win;
      logic [7:0]    snap;
      bit            frame, fetch, sel, tmo;
      int            k;
      rise  = m_deb & ~m_deb_d;
      frame = n_int && !n_int_next;
      fetch = bus_m1 && bus_mreq && (bus_a == 16'h0066);
      sel   = map_active && bus_ioreq && bus_rd && (bus_a == 16'hFEFF);
      elig  = m_pend & ~mask;
      gclr  = 0;
      tmo   = 0;
      snap  = {m_act, m_tflag, m_grant, m_pend};
      if (m_low) begin
        m_low_cycles++;
        if (fetch) m_low = 0;
        else if (m_low_cycles == TMO) begin
          m_low = 0; m_act = 0; tmo = 1;
        end
      end else if (m_act) begin
        if (nmi_done) m_act = 0;
      end else if (m_armed) begin
        if (frame && elig != 0) begin
          k = 0;
          for (int i = 3; i >= 0; i--) if (elig[i]) k = i;
          m_grant = 2'(k);
          gclr[k] = 1'b1;
          m_low = 1; m_act = 1; m_armed = 0; m_low_cycles = 0;
        end else if (m_pend == 0) m_armed = 0;
      end else if (m_pend != 0) m_armed = 1;
      m_pend = ~mask & ((m_pend & ~gclr) | rise);
      ndeb = m_deb;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][HL-2:0], req[i]};
        win = m_hist[i][HL-1:2];
        if (!m_deb[i] && (&win)) ndeb[i] = 1'b1;
        else if (m_deb[i] && !(|win)) ndeb[i] = 1'b0;
      end
      m_deb_d = m_deb;
      m_deb   = ndeb;
      m_dout  = sel ? snap : 8'h00;
      if (tmo) m_tflag = 1;
      else if (sel && !m_dact) m_tflag = 0;
      m_dact = sel;
    end
  end

  always @(negedge clk28) begin
    chk("n_nmi",        {7'd0, n_nmi},        {7'd0, !m_low});
    chk("grant",        {6'd0, grant},        {6'd0, m_grant});
    chk("nmi_active",   {7'd0, nmi_active},   {7'd0, m_act});
    chk("d_out",        d_out,                m_dout);
    chk("d_out_active", {7'd0, d_out_active}, {7'd0, m_dact});
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (all called right after a falling clock edge)
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic bus_idle();
    bus_m1 = 0; bus_mreq = 0; bus_ioreq = 0; bus_rd = 0; bus_wr = 0;
    bus_a = 16'h0000;
  endtask

  task automatic frame_edge();
    n_int = 1; n_int_next = 0;
    @(negedge clk28);
    n_int_next = 1;
  endtask

  task automatic fetch_vec();
    bus_m1 = 1; bus_mreq = 1; bus_a = 16'h0066;
    @(negedge clk28);
    bus_idle();
  endtask

  task automatic done_pulse();
    nmi_done = 1;
    @(negedge clk28);
    nmi_done = 0;
  endtask

  task automatic status_read(output logic [7:0] v);
    bus_ioreq = 1; bus_rd = 1; bus_a = 16'hFEFF;
    @(negedge clk28);
    v = d_out;
    bus_idle();
  endtask

  task automatic accept(input int idx);
    req[idx] = 1;
    tick((1 << DW) + 6);
    req[idx] = 0;
    tick(2);
  endtask

  logic [7:0] v;
  int         cnt;
  int         fc;
  bit         fetch_on;

  initial begin
    rst_n = 0;
    tick(3);
    rst_n = 1;
    chk("rst_n_nmi", {7'd0, n_nmi}, 8'd1);
    chk("rst_grant", {6'd0, grant}, 8'd0);
    chk("rst_act",   {7'd0, nmi_active}, 8'd0);
    chk("rst_dout",  d_out, 8'h00);
    chk("rst_dact",  {7'd0, d_out_active}, 8'd0);

    // Debounce: short highs rejected, long high accepted
    for (int r = 0; r < 5; r++) begin
      req[1] = 1; tick((1 << DW) - 10);
      req[1] = 0; tick((1 << DW) - 10);
    end
    tick(4);
    status_read(v);
    chk("deb_short", v, 8'h00);
    req[1] = 1; tick((1 << DW) + 3);
    req[1] = 0; tick(3);
    status_read(v);
    chk("deb_long", v, 8'h02);

    // Grant of requester 1
    frame_edge();
    chk("g1_nmi", {7'd0, n_nmi}, 8'd0);
    chk("g1_grant", {6'd0, grant}, 8'd1);
    chk("g1_act", {7'd0, nmi_active}, 8'd1);
    fetch_vec();
    chk("g1_rel", {7'd0, n_nmi}, 8'd1);
    done_pulse();
    chk("g1_done", {7'd0, nmi_active}, 8'd0);
    status_read(v);
    chk("g1_stat", v, 8'h10);

    // Priority between requesters 0 and 3
    req[0] = 1; req[3] = 1;
    tick((1 << DW) + 6);
    req[0] = 0; req[3] = 0;
    tick(2);
    frame_edge();
    chk("pr_first", {6'd0, grant}, 8'd0);
    status_read(v);
    chk("pr_stat", v, 8'h88);
    fetch_vec();
    done_pulse();
    tick(3);
    frame_edge();
    chk("pr_second", {6'd0, grant}, 8'd3);
    chk("pr_nmi", {7'd0, n_nmi}, 8'd0);
    fetch_vec();
    done_pulse();

    // Timeout with no vector fetch
    accept(2);
    frame_edge();
    chk("to_nmi", {7'd0, n_nmi}, 8'd0);
    cnt = 0;
    while (n_nmi == 1'b0 && cnt < 4 * TMO) begin
      cnt++;
      @(negedge clk28);
    end
    chk("to_len", 8'(cnt >> 1), 8'(TMO >> 1));
    chk("to_act", {7'd0, nmi_active}, 8'd0);
    status_read(v);
    chk("to_stat1", v, 8'h60);
    tick(2);
    status_read(v);
    chk("to_stat2", v, 8'h20);

    // Mask removes a pending request before the edge
    accept(2);
    status_read(v);
    chk("mk_pend", v, 8'h24);
    mask = 4'b0100;
    tick(2);
    frame_edge();
    for (int i = 0; i < 5; i++) begin
      chk("mk_no_nmi", {7'd0, n_nmi}, 8'd1);
      tick(1);
    end
    status_read(v);
    chk("mk_stat", v, 8'h20);
    mask = 4'b0000;
    map_active = 0;
    bus_ioreq = 1; bus_rd = 1; bus_a = 16'hFEFF;
    @(negedge clk28);
    chk("mk_gated", {7'd0, d_out_active}, 8'd0);
    bus_idle();
    map_active = 1;
    tick(2);

    // Asynchronous reset while /NMI is held low
    accept(0);
    frame_edge();
    chk("rs_low", {7'd0, n_nmi}, 8'd0);
    #3 rst_n = 0;
    #1;
    chk("rs_nmi",  {7'd0, n_nmi}, 8'd1);
    chk("rs_act",  {7'd0, nmi_active}, 8'd0);
    chk("rs_grant", {6'd0, grant}, 8'd0);
    chk("rs_dout", d_out, 8'h00);
    @(negedge clk28);
    tick(2);
    rst_n = 1;
    tick(2);
    status_read(v);
    chk("rs_stat", v, 8'h00);

    // Randomized traffic with periodic frames
    fc = 0;
    fetch_on = 1;
    for (int c = 0; c < 5000; c++) begin
      if (c % 700 == 0) fetch_on = ($urandom_range(0, 2) != 0);
      fc = (fc + 1) % FP;
      n_int      = (fc >= 4);
      n_int_next = (((fc + 1) % FP) >= 4);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 23) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 199) == 0) mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0)  mask = 4'h0;
      nmi_done   = ($urandom_range(0, 15) == 0);
      map_active = ($urandom_range(0, 3) != 0);
      bus_d      = 8'($urandom);
      bus_idle();
      case ($urandom_range(0, 15))
        0, 1: if (fetch_on) begin bus_m1 = 1; bus_mreq = 1; bus_a = 16'h0066; end
        2: begin bus_ioreq = 1; bus_rd = 1; bus_a = 16'hFEFF; end
        3: begin bus_ioreq = 1; bus_wr = 1; bus_a = 16'hFEFF; end
        4: begin bus_m1 = 1; bus_mreq = 1; bus_a = 16'($urandom); end
        5: begin bus_ioreq = 1; bus_rd = 1; bus_a = 16'($urandom); end
        default: ;
      endcase
      @(negedge clk28);
    end
    bus_idle();
    nmi_done = 0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nmi_arbiter.md
# nmi_arbiter

Shares the single Z80 /NMI line between four NMI requesters: magic button, pause button, divMMC button and external expansion NMI. Requests are synchronised, debounced and latched as pending. One request is granted at a time, aligned to the frame interrupt edge. The block then holds /NMI until the CPU fetches the NMI vector and waits for the handler to report completion. It sits between the button/expansion inputs and the magic-mode logic, and exposes a status byte on the magic I/O port.

## Interface
- DEBOUNCE_W, 16, debounce counter width; an input must be stable for 2^DEBOUNCE_W clk28 cycles to be accepted.
- TIMEOUT_W, 20, vector-fetch timeout counter width; timeout is 2^TIMEOUT_W cycles.
- clk28  in  1  system clock, 28 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- bus  cpu_bus  -  CPU bus monitor (mreq, ioreq, m1, rd, wr, a[15:0], d[7:0]); observed only, never driven.
- req  in  4  raw requests, active-high, asynchronous: [0] magic, [1] pause, [2] divMMC, [3] external.
- mask  in  4  1 = requester disabled.
- n_int, n_int_next  in  1 each  current and next-cycle frame interrupt level.
- map_active  in  1  magic ROM mapped; gates the status port.
- nmi_done  in  1  single-cycle pulse: handler finished (RETN path).
- n_nmi  out  1  CPU /NMI, active-low.
- grant  out  2  index of the last granted requester.
- nmi_active  out  1  high from grant until nmi_done or timeout.
- d_out  out  8  status byte.
- d_out_active  out  1  status byte drive enable.

## Operation
- Input path per requester:
  - 2-flop synchroniser.
  - Debounce counter reset on any change of the synchronised level; the debounced level updates when the counter saturates.
- Pending latch per requester:
  - Set on a rising edge of the debounced level when the matching mask bit is 0.
  - Cleared when granted, or on the cycle after its mask bit reads 1.
- Frame edge: n_int==1 && n_int_next==0.
- FSM states: IDLE, WAIT_EDGE, ASSERT, SERVICE.
  - IDLE: any pending bit set -> WAIT_EDGE.
  - WAIT_EDGE: at the frame edge, pick the lowest-index pending bit (fixed priority: magic > pause > divMMC > external). Load grant, clear that pending bit, drive n_nmi=0, set nmi_active, clear the timeout counter -> ASSERT. If all pending bits cleared by mask -> IDLE.
  - ASSERT: bus.m1 && bus.mreq && bus.a==16'h0066 -> n_nmi=1 -> SERVICE. Timeout counter saturates first -> n_nmi=1, nmi_active=0, set timeout flag -> IDLE.
  - SERVICE: nmi_done -> nmi_active=0 -> IDLE. New requests, including from the granted source, only latch as pending.
- nmi_done outside SERVICE is ignored.
- Status port select: map_active && bus.ioreq && bus.rd && bus.a==16'hFEFF.
  - d_out = {nmi_active, timeout_flag, grant[1:0], pending[3:0]}, captured in a register.
  - d_out_active = registered select.
  - timeout_flag clears on the first cycle of a status read; a timeout in that same cycle takes precedence and sets it.
- Writes to the port are ignored.

## Timing
- Reset values: n_nmi=1, grant=0, nmi_active=0, d_out=0, d_out_active=0, pending=0, timeout_flag=0, FSM=IDLE, debounced levels=0, counters=0.
- Request latency:
  - 2 synchroniser cycles + 2^DEBOUNCE_W stable cycles + 1 cycle to pending.
  - Then up to one frame until the edge.
  - n_nmi falls on the clock following the edge cycle.
- n_nmi rises on the clock after the 0x0066 M1 fetch cycle is seen.
- d_out_active asserts 1 cycle after the select becomes true and deasserts 1 cycle after it falls.
- Two requests pending at the same edge: one grant per frame edge. The lower index goes first; the other is served at the first frame edge after nmi_done.
- A pending edge arriving while ASSERT or SERVICE is active is held; no request is lost and duplicates collapse to one.
- Asynchronous reset in any state releases n_nmi within the reset assertion, with no glitch low.

## Test plan
- Debounce: req[1] toggles with high periods of 2^DEBOUNCE_W−10 cycles -> pending stays 0. Hold high for 2^DEBOUNCE_W+3 cycles -> pending[1]=1.
- Grant: pending[1]=1, then frame edge -> n_nmi=0 on the next clock, grant=1, nmi_active=1. M1 fetch at 0x0066 -> n_nmi=1 next clock. nmi_done -> nmi_active=0, FSM=IDLE.
- Priority: req[0] and req[3] accepted in the same cycle -> first grant=0. After nmi_done, second grant=3 at the next frame edge. Status reads 0x80|0x08 during the first service.
- Timeout: grant with no 0x0066 fetch -> n_nmi=1 after 2^TIMEOUT_W cycles and nmi_active=0. Status bit6=1; a second status read returns bit6=0.
- Mask: pending[2]=1, then mask[2]=1 before the edge -> pending[2]=0, no /NMI pulse. Port read with map_active=0 -> d_out_active stays 0.
- Reset: assert rst_n low during ASSERT -> n_nmi=1, all outputs at reset values, FSM=IDLE.
